// File: rtl/hwt_probe_if.sv
// Stimulus/response bundle between hwt_probe and the device it exercises.
// Latency: none, wiring only.
// Backpressure: none; start is a single-cycle request, ignored while busy.
interface hwt_probe_if;
    logic       start;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       y_dut;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;

    // Probe side: drives stimulus and results, receives start and the DUT response.
    modport master (
        input  start,
        input  y_dut,
        output A,
        output B,
        output C,
        output D,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_vec,
        output first_fail_valid
    );

    // Environment side: requests sweeps, returns the DUT response, reads results.
    modport slave (
        output start,
        output y_dut,
        input  A,
        input  B,
        input  C,
        input  D,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_vec,
        input  first_fail_valid
    );
endinterface

// File: rtl/hwt_probe.sv
// Sweeps all 16 {A,B,C,D} vectors into a non_hwt instance and checks Y = D & ((A & B) | C).
// Latency: 16*(SETTLE_CYC+2) cycles from accepted start to done; results land one edge after each sample.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module hwt_probe #(
    parameter int SETTLE_CYC = 2   // hold cycles before sampling, 0..15
) (
    input  logic         clk,
    input  logic         rst,
    hwt_probe_if.master  bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
    localparam logic [3:0] LAST_VEC    = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] vec;          // {A,B,C,D} currently presented
    logic [3:0] settle_cnt;
    logic       busy;
    logic       done;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;

    logic       golden;
    logic       mismatch;

    // Reference non_hwt function of the vector being presented.
    assign golden   = vec[0] & ((vec[3] & vec[2]) | vec[1]);
    assign mismatch = (bus.y_dut != golden);

    // Sweep controller: one register set, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= 4'd0;
            settle_cnt       <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                // Restart from DONE behaves exactly like a start from IDLE.
                IDLE, DONE: begin
                    if (bus.start) begin
                        state            <= SETTLE;
                        vec              <= 4'd0;
                        settle_cnt       <= SETTLE_LOAD;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= 5'd0;
                        first_fail_vec   <= 4'd0;
                        first_fail_valid <= 1'b0;
                    end
                end

                // Hold the vector for SETTLE_CYC+1 cycles before sampling.
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                // Compare the response, then step to the next vector or finish.
                SAMPLE: begin
                    if (mismatch) begin
                        // At most 16 increments per sweep, so 5 bits never wrap.
                        err_count <= err_count + 5'd1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        // Vector stays at 4'hF so the DUT sees a stable input in DONE.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= SETTLE;
                        vec        <= vec + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A                = vec[3];
    assign bus.B                = vec[2];
    assign bus.C                = vec[1];
    assign bus.D                = vec[0];
    assign bus.busy             = busy;
    assign bus.done             = done;
    // err_count is only meaningful once the sweep has finished.
    assign bus.pass             = done & (err_count == 5'd0);
    assign bus.err_count        = err_count;
    assign bus.first_fail_vec   = first_fail_vec;
    assign bus.first_fail_valid = first_fail_valid;

endmodule

// File: doc/hwt_probe.md
# hwt_probe

Sequential stimulus generator and response checker for the 4-input `non_hwt` golden function, Y = D & ((A & B) | C). It sweeps all 16 input vectors into a device under test and samples the returned Y. Each sample is compared against the golden value, and the block reports mismatches. It sits beside a `non_hwt` / HWT instance as the driving and checking end of that interface, and is the hook for detecting trojan-modified variants.

## Interface
- `SETTLE_CYC`, default 2: cycles a vector is held before Y is sampled. Legal range 0..15.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle request to begin a sweep.
- `A`, `B`, `C`, `D` out 1 each: registered stimulus to the DUT.
- `y_dut` in 1: DUT output, sampled synchronously.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until the next accepted start or reset.
- `pass` out 1: `done & (err_count == 0)`.
- `err_count` out 5: number of mismatching vectors, 0..16.
- `first_fail_vec` out 4: {A,B,C,D} of the first mismatch.
- `first_fail_valid` out 1: `first_fail_vec` holds a captured value.

## Operation
- Vector encoding: `vec[3:0] = {A,B,C,D}`, swept 0 -> 15 ascending. `A..D` are driven directly from `vec` registers.
- Golden value: `g = vec[0] & ((vec[3] & vec[2]) | vec[1])`. It is 1 only for vectors 3, 7, 11, 13, 15.
- IDLE:
  - Outputs idle.
  - `start` -> clear `vec`, `err_count`, `first_fail_*`, `done`; load `settle_cnt = SETTLE_CYC`; go to SETTLE.
- SETTLE:
  - `busy = 1`.
  - If `settle_cnt == 0`, go to SAMPLE; else decrement.
- SAMPLE:
  - `busy = 1`.
  - If `y_dut != g`: increment `err_count`. If `first_fail_valid == 0`, capture `vec` and set `first_fail_valid`.
  - If `vec == 15`, go to DONE; else increment `vec`, reload `settle_cnt`, go to SETTLE.
- DONE:
  - `done = 1`, `busy = 0`. `A..D` hold the last vector (4'hF).
  - `start` restarts exactly as from IDLE, clearing all results.
- `start` while `busy` is ignored.
- `err_count` cannot exceed 16; no wrap logic is required.
- Reset at any point, including mid-sweep:
  - Next cycle the block is in IDLE.
  - All outputs are 0: `A..D`, `busy`, `done`, `pass`, `err_count`, `first_fail_vec`, `first_fail_valid`.
  - No partial results are retained.
- `rst` and `start` in the same cycle: reset wins.

## Timing
- Start accepted at edge 0:
  - `busy` and vector 0 appear after edge 0.
  - Each vector occupies SETTLE_CYC+1 SETTLE cycles plus 1 SAMPLE cycle, i.e. SETTLE_CYC+2 cycles.
  - `done` asserts after edge 16*(SETTLE_CYC+2).
- `y_dut` is sampled at the end of the SAMPLE cycle. The vector has been stable for SETTLE_CYC+2 edges at that point.
- `err_count` and `first_fail_*` update one edge after their SAMPLE cycle.
- `pass` is valid whenever `done == 1`. It is 0 otherwise.

## Test plan
- Loopback `y_dut` = golden of `A..D`, SETTLE_CYC=2, pulse start:
  - `done` after 64 cycles.
  - `pass=1`, `err_count=0`, `first_fail_valid=0`.
  - `busy` high exactly 64 cycles.
- `y_dut` stuck at 0 -> `err_count=5`, `first_fail_vec=4'd3`, `pass=0`.
- `y_dut` stuck at 1 -> `err_count=11`, `first_fail_vec=4'd0`.
- Trojan model `y_dut = golden ^ (A&B&C&D)` -> `err_count=1`, `first_fail_vec=4'd15`, `pass=0`.
- Reset during vector 7:
  - All outputs 0 next cycle.
  - Subsequent start sweeps from vector 0 with clean counts.
- `start` pulses while `busy` -> no effect on timing or counts.
- `start` in DONE after a failing run, with loopback golden -> counts cleared, second run ends `pass=1`.
- SETTLE_CYC=0 -> done after 32 cycles with correct results.
